// File: rtl/centroid_div_if.sv
`default_nettype none
// ============================================================================
// Module      : centroid_div_if
// Description : Bundle of the start/operand and result signals of
//               centroid_div.
//               master : drives eof, m00, m10 and m01; observes the results.
//               slave  : the divider; consumes the operands and drives
//                        x_c, y_c, valid, busy, div_zero and overrun.
// Revision    : 1.0 - initial release
// ============================================================================
interface centroid_div_if #(
    parameter int DW = 30,
    parameter int NW = 21,
    parameter int QW = 11
) ();
    logic          eof;
    logic [NW-1:0] m00;
    logic [DW-1:0] m10;
    logic [DW-1:0] m01;
    logic [QW-1:0] x_c;
    logic [QW-1:0] y_c;
    logic          valid;
    logic          busy;
    logic          div_zero;
    logic          overrun;

    modport master (
        output eof, m00, m10, m01,
        input  x_c, y_c, valid, busy, div_zero, overrun
    );

    modport slave (
        input  eof, m00, m10, m01,
        output x_c, y_c, valid, busy, div_zero, overrun
    );
endinterface
`default_nettype wire

// File: rtl/centroid_div.sv
`default_nettype none
// ============================================================================
// Module      : centroid_div
// Description : End-of-frame centroid divider. On eof it latches the pixel
//               count m00 and the moments m10/m01, then runs two restoring
//               dividers in parallel (one quotient bit per clock, MSB first,
//               DW iterations) to produce x_c = floor(m10/m00) and
//               y_c = floor(m01/m00), each saturated to 2^QW-1.
//               m00 == 0 finishes after a single cycle with div_zero set.
// Ports       : clk, rst (synchronous, active-high)
//               bus.eof/m00/m10/m01          - start pulse and operands
//               bus.x_c/y_c/div_zero         - results, held until next valid
//               bus.valid                    - one-cycle result strobe
//               bus.busy                     - division in progress
//               bus.overrun                  - sticky: eof seen while busy
// Revision    : 1.0 - initial release
// ============================================================================
module centroid_div #(
    parameter int DW = 30,
    parameter int NW = 21,
    parameter int QW = 11
) (
    input  wire logic      clk,
    input  wire logic      rst,
    centroid_div_if.slave  bus
);
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DIV  = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_next_state;

    logic [CW-1:0] r_cnt;
    logic [NW-1:0] r_m00;
    // Each of these holds the dividend at start; quotient bits are shifted in
    // at the LSB while dividend bits leave at the MSB, so after DW steps the
    // register holds the full DW-bit quotient.
    logic [DW-1:0] r_qdx;
    logic [DW-1:0] r_qdy;
    logic [NW:0]   r_remx;
    logic [NW:0]   r_remy;

    logic [QW-1:0] r_xc;
    logic [QW-1:0] r_yc;
    logic          r_valid;
    logic          r_div_zero;
    logic          r_overrun;

    logic          w_busy;
    logic          w_start;
    logic          w_zero;
    logic          w_iter;
    logic          w_last;

    // One restoring step per divider. The shifted remainder is kept one bit
    // wider than the stored remainder so the compare sees every bit.
    logic [NW+1:0] w_shx;
    logic [NW+1:0] w_shy;
    logic          w_gex;
    logic          w_gey;
    logic [NW:0]   w_diffx;
    logic [NW:0]   w_diffy;
    logic [NW:0]   w_nremx;
    logic [NW:0]   w_nremy;
    logic [DW-1:0] w_nqx;
    logic [DW-1:0] w_nqy;

    function automatic logic [QW-1:0] sat(input logic [DW-1:0] q);
        if (|q[DW-1:QW]) begin
            return '1;
        end
        return q[QW-1:0];
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.eof) w_next_state = S_DIV;
            S_DIV:   if (w_zero || w_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy  = (r_state == S_DIV);
        w_start = (r_state == S_IDLE) && bus.eof;
        w_zero  = w_busy && (r_m00 == '0);
        w_iter  = w_busy && (r_m00 != '0);
        w_last  = w_iter && (r_cnt == CW'(DW - 1));
    end

    // ----------------------------------------------------------- datapath
    always_comb begin
        w_shx   = {r_remx, r_qdx[DW-1]};
        w_shy   = {r_remy, r_qdy[DW-1]};
        w_gex   = (w_shx >= {2'b00, r_m00});
        w_gey   = (w_shy >= {2'b00, r_m00});
        w_diffx = w_shx[NW:0] - {1'b0, r_m00};
        w_diffy = w_shy[NW:0] - {1'b0, r_m00};
        w_nremx = w_gex ? w_diffx : w_shx[NW:0];
        w_nremy = w_gey ? w_diffy : w_shy[NW:0];
        w_nqx   = {r_qdx[DW-2:0], w_gex};
        w_nqy   = {r_qdy[DW-2:0], w_gey};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_m00      <= '0;
            r_qdx      <= '0;
            r_qdy      <= '0;
            r_remx     <= '0;
            r_remy     <= '0;
            r_xc       <= '0;
            r_yc       <= '0;
            r_valid    <= 1'b0;
            r_div_zero <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_start) begin
                r_m00  <= bus.m00;
                r_qdx  <= bus.m10;
                r_qdy  <= bus.m01;
                r_remx <= '0;
                r_remy <= '0;
                r_cnt  <= '0;
            end else if (w_zero) begin
                r_xc       <= '0;
                r_yc       <= '0;
                r_div_zero <= 1'b1;
                r_valid    <= 1'b1;
            end else if (w_iter) begin
                r_remx <= w_nremx;
                r_remy <= w_nremy;
                r_qdx  <= w_nqx;
                r_qdy  <= w_nqy;
                r_cnt  <= r_cnt + CW'(1);
                if (w_last) begin
                    r_xc       <= sat(w_nqx);
                    r_yc       <= sat(w_nqy);
                    r_div_zero <= 1'b0;
                    r_valid    <= 1'b1;
                end
            end
            // A start request during a division is dropped but remembered.
            if (bus.eof && w_busy) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign bus.x_c      = r_xc;
    assign bus.y_c      = r_yc;
    assign bus.valid    = r_valid;
    assign bus.busy     = w_busy;
    assign bus.div_zero = r_div_zero;
    assign bus.overrun  = r_overrun;
endmodule
`default_nettype wire
